wb_port_arbiter: RTL

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_arb_pkg.sv | 19 +
 rtl/wb_md_fifo.sv | 71 +++++++
 rtl/wb_port_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types for the writeback port arbiter: FSM states, result-buffer entry
// layout and the hard-wired zero register.
package wb_arb_pkg;

  localparam int         MD_DEPTH = 2;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ST_ARB,
    ST_DRAIN
  } arb_state_e;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
  } md_entry_t;

endpackage

// File: rtl/wb_md_fifo.sv
// Two-entry multiply/divide result buffer with per-entry squash by destination
// register; squashed entries stay in order until the arbiter removes them.
module wb_md_fifo
  import wb_arb_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  logic [4:0]  push_rd,
  input  logic [31:0] push_data,
  input  logic        pop,
  input  logic        squash,
  input  logic [4:0]  squash_rd,
  output logic        ready,
  output logic        head_present,
  output md_entry_t   head,
  output logic [31:0] pending_mask
);

  logic [1:0] count_q, count_d;
  md_entry_t  ent_q [MD_DEPTH];
  md_entry_t  ent_d [MD_DEPTH];
  md_entry_t  kept  [MD_DEPTH];
  md_entry_t  new_ent;

  // A result for register 0 is stored invalid, so it drains without a write.
  assign new_ent = '{valid: (push_rd != REG_ZERO), rd: push_rd, data: push_data};

  always_comb begin
    for (int i = 0; i < MD_DEPTH; i++) begin
      kept[i] = ent_q[i];
      if (squash && ent_q[i].rd == squash_rd) kept[i].valid = 1'b0;
    end
    ent_d   = kept;
    count_d = count_q;
    if (pop) begin
      ent_d[0]       = kept[1];
      ent_d[1]       = kept[1];
      ent_d[1].valid = 1'b0;
      count_d        = count_q - 2'd1;
    end
    if (push) begin
      if (count_d == 2'd0) ent_d[0] = new_ent;
      else                 ent_d[1] = new_ent;
      count_d = count_d + 2'd1;
    end
  end

  // NOTE: only the count and valid bits need reset; payloads are never observed
  // while invalid, so leaving them unreset keeps the storage a plain register array.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= 2'd0;
      for (int i = 0; i < MD_DEPTH; i++) ent_q[i].valid <= 1'b0;
    end else begin
      count_q <= count_d;
      ent_q   <= ent_d;
    end
  end

  assign ready        = (count_q < 2'd2);
  assign head_present = (count_q != 2'd0);
  assign head         = ent_q[0];

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < MD_DEPTH; i++)
      if (ent_q[i].valid) pending_mask[ent_q[i].rd] = 1'b1;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the pipeline writeback
// stage and buffered multiply/divide results. Optional WB_ARB_STATS_EN adds conflict_cnt.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic        wb_rwe,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  output logic        md_ready,
  output logic        stall,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data,
  output logic [31:0] pending_mask
`ifdef WB_ARB_STATS_EN
  ,
  output logic [15:0] conflict_cnt
`endif
);

  localparam logic [3:0] STARVE_LAST = 4'(STARVE_LIMIT - 1);

  arb_state_e  state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_addr_q, rf_addr_d;
  logic [31:0] rf_data_q, rf_data_d;
  logic        pipe_req, head_live, head_dead, head_present, pop, squash;
  md_entry_t   head;

  wb_md_fifo u_fifo (
    .clock        (clock),
    .reset        (reset),
    .push         (md_valid & md_ready),
    .push_rd      (md_rd),
    .push_data    (md_data),
    .pop          (pop),
    .squash       (squash),
    .squash_rd    (wb_rd),
    .ready        (md_ready),
    .head_present (head_present),
    .head         (head),
    .pending_mask (pending_mask)
  );

  assign pipe_req  = wb_valid & wb_rwe & (wb_rd != REG_ZERO);
  assign head_live = head_present & head.valid;
  assign head_dead = head_present & ~head.valid;

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    pop       = 1'b0;
    squash    = 1'b0;
    case (state_q)
      ST_DRAIN: begin
        pop      = head_present;
        rf_we_d  = head_live;
        if (head_live) begin
          rf_addr_d = head.rd;
          rf_data_d = head.data;
        end
        starve_d = 4'd0;
        state_d  = ST_ARB;
      end
      default: begin
        if (pipe_req) begin
          rf_we_d   = 1'b1;
          rf_addr_d = wb_rd;
          rf_data_d = wb_data;
          squash    = 1'b1;
          pop       = head_dead;
          if (head_dead) starve_d = 4'd0;
          else if (head_live) begin
            if (starve_q == STARVE_LAST) begin
              starve_d = 4'd0;
              state_d  = ST_DRAIN;
            end else begin
              starve_d = starve_q + 4'd1;
            end
          end
        end else if (head_present) begin
          pop      = 1'b1;
          rf_we_d  = head_live;
          if (head_live) begin
            rf_addr_d = head.rd;
            rf_data_d = head.data;
          end
          starve_d = 4'd0;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_ARB;
      starve_q  <= 4'd0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= 5'd0;
      rf_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

  assign stall   = (state_q == ST_DRAIN);
  assign rf_we   = rf_we_q;
  assign rf_addr = rf_addr_q;
  assign rf_data = rf_data_q;

`ifdef WB_ARB_STATS_EN
  logic [15:0] conflict_q, conflict_d;

  always_comb begin
    conflict_d = conflict_q;
    if (pipe_req && head_live && conflict_q != 16'hFFFF) conflict_d = conflict_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) conflict_q <= 16'd0;
    else       conflict_q <= conflict_d;
  end

  assign conflict_cnt = conflict_q;
`endif

endmodule
